// File: rtl/fx_master_if.sv
// Bundle of the fx_master command stream, response stream and fx register bus.
// The master modport is the fx_master side; slave is the host/responder side.
interface fx_master_if;
  logic [7:0]  cmd_data;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [7:0]  rsp_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic        bad_op;

  modport master (
    input  cmd_data, cmd_vld, rsp_rdy, fx_q,
    output cmd_rdy, rsp_data, rsp_vld, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, bad_op
  );

  modport slave (
    output cmd_data, cmd_vld, rsp_rdy, fx_q,
    input  cmd_rdy, rsp_data, rsp_vld, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, bad_op
  );
endinterface

// File: rtl/fx_master.sv
// fx register bus initiator: decodes byte-wide write / burst-read frames from the
// command stream and issues single-cycle fx_wr / fx_rd strobes, one read in flight.
module fx_master #(
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  OP_WR  = 8'h57,
  parameter logic [7:0]  OP_RD  = 8'h52
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  fx_master_if.master  bus
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("fx_master: RD_LAT must be in 1..4");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_A2, S_A1, S_A0, S_WDAT, S_WR, S_RCNT, S_RD, S_RWAIT, S_RSP, S_RNEXT
  } state_e;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic        is_rd_q, is_rd_d;
  logic [21:0] addr_q, addr_d;
  logic [21:0] fx_waddr_q, fx_waddr_d;
  logic [21:0] fx_raddr_q, fx_raddr_d;
  logic [7:0]  fx_data_q, fx_data_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  lat_q, lat_d;
  logic        bad_op_q, bad_op_d;

  logic cmd_rdy, cmd_fire, rsp_vld, rsp_fire;

  // Flow control and strobes are pure state decodes, so reset drops them at once.
  assign cmd_rdy  = state_q inside {S_IDLE, S_A2, S_A1, S_A0, S_WDAT, S_RCNT};
  assign rsp_vld  = (state_q == S_RSP);
  assign cmd_fire = bus.cmd_vld && cmd_rdy;
  assign rsp_fire = rsp_vld && bus.rsp_rdy;

  assign bus.cmd_rdy  = cmd_rdy;
  assign bus.rsp_vld  = rsp_vld;
  assign bus.rsp_data = rsp_data_q;
  assign bus.fx_wr    = (state_q == S_WR);
  assign bus.fx_rd    = (state_q == S_RD);
  assign bus.fx_waddr = fx_waddr_q;
  assign bus.fx_raddr = fx_raddr_q;
  assign bus.fx_data  = fx_data_q;
  assign bus.bad_op   = bad_op_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    fx_waddr_d = fx_waddr_q;
    fx_raddr_d = fx_raddr_q;
    fx_data_d  = fx_data_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    bad_op_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if (bus.cmd_data == OP_WR || bus.cmd_data == OP_RD) begin
            is_rd_d = (bus.cmd_data == OP_RD);
            state_d = S_A2;
          end else begin
            bad_op_d = 1'b1;
          end
        end
      end
      S_A2: if (cmd_fire) begin
        addr_d[21:16] = bus.cmd_data[5:0];
        state_d       = S_A1;
      end
      S_A1: if (cmd_fire) begin
        addr_d[15:8] = bus.cmd_data;
        state_d      = S_A0;
      end
      S_A0: if (cmd_fire) begin
        addr_d[7:0] = bus.cmd_data;
        state_d     = is_rd_q ? S_RCNT : S_WDAT;
      end
      S_WDAT: if (cmd_fire) begin
        fx_data_d  = bus.cmd_data;
        fx_waddr_d = addr_q;
        state_d    = S_WR;
      end
      S_WR: state_d = S_IDLE;
      S_RCNT: if (cmd_fire) begin
        fx_raddr_d = addr_q;
        cnt_d      = (bus.cmd_data == 8'd0) ? 9'd256 : {1'b0, bus.cmd_data};
        state_d    = S_RD;
      end
      S_RD: begin
        cnt_d   = cnt_q - 9'd1;
        lat_d   = 3'd0;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        if (lat_q == LAT_LAST) begin
          rsp_data_d = bus.fx_q;
          state_d    = S_RSP;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_RSP: if (rsp_fire) begin
        // 22-bit add wraps 3FFFFF -> 000000 on its own.
        fx_raddr_d = fx_raddr_q + 22'd1;
        state_d    = (cnt_q == 9'd0) ? S_IDLE : S_RNEXT;
      end
      S_RNEXT: state_d = S_RD;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      fx_waddr_q <= '0;
      fx_raddr_q <= '0;
      fx_data_q  <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      bad_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      fx_waddr_q <= fx_waddr_d;
      fx_raddr_q <= fx_raddr_d;
      fx_data_q  <= fx_data_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      bad_op_q   <= bad_op_d;
    end
  end

endmodule

// File: tb/tb_fx_master.sv
// Self-checking bench for fx_master: randomized frames, a latency-modelled responder
// and a negedge bus monitor compared against a frame-level model.
module tb_fx_master;
  localparam int         RD_LAT = 1;
  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] OP_RD  = 8'h52;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  fx_master_if bus ();

  fx_master #(.RD_LAT(RD_LAT), .OP_WR(OP_WR), .OP_RD(OP_RD)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [21:0] a;
    logic [7:0]  d;
    int          c;
  } ev_t;

  ev_t wr_log[$];
  ev_t rd_log[$];
  ev_t rsp_log[$];
  ev_t acc_log[$];
  int  cyc       = 0;
  int  bad_cnt   = 0;
  int  viol_both = 0;
  int  viol_rdv  = 0;
  int  viol_hold = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  logic [7:0] seed       = 8'h00;
  logic [8:0] q_override = 9'h000;

  // Responder contents: a fixed scramble of the address, or a forced byte.
  function automatic logic [7:0] resp_byte(input logic [21:0] a);
    logic [7:0] m;
    if (q_override[8]) return q_override[7:0];
    m = 8'(a[7:0] * 8'd29);
    return m ^ a[15:8] ^ {2'b00, a[21:16]} ^ seed;
  endfunction

  // Bus monitor, sampling mid-cycle.
  always @(negedge clk_sys) begin
    cyc++;
    if (rst_n) begin
      if (bus.cmd_vld && bus.cmd_rdy) acc_log.push_back('{a: 22'd0, d: bus.cmd_data, c: cyc});
      if (bus.fx_wr) wr_log.push_back('{a: bus.fx_waddr, d: bus.fx_data, c: cyc});
      if (bus.fx_rd) rd_log.push_back('{a: bus.fx_raddr, d: 8'h00, c: cyc});
      if (bus.rsp_vld && bus.rsp_rdy) rsp_log.push_back('{a: 22'd0, d: bus.rsp_data, c: cyc});
      if (bus.bad_op) bad_cnt++;
      if (bus.fx_wr && bus.fx_rd) viol_both++;
      if (bus.fx_rd && bus.rsp_vld) viol_rdv++;
      if (prev_stall && (!bus.rsp_vld || bus.rsp_data !== prev_data)) viol_hold++;
      prev_stall = bus.rsp_vld && !bus.rsp_rdy;
      prev_data  = bus.rsp_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Responder: data valid exactly RD_LAT cycles after the fx_rd cycle, junk otherwise.
  initial begin : responder
    int         age;
    logic [7:0] pend;
    age = -1;
    pend = 8'h00;
    bus.fx_q = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      if (age >= 0) age++;
      if (age == RD_LAT) bus.fx_q = pend;
      else bus.fx_q = 8'($urandom);
      if (age > RD_LAT) age = -1;
      @(negedge clk_sys);
      if (rst_n && bus.fx_rd) begin
        pend = resp_byte(bus.fx_raddr);
        age  = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.cmd_vld  = 1'b0;
        bus.cmd_data = 8'($urandom);
        tick();
      end
    end
    bus.cmd_vld  = 1'b1;
    bus.cmd_data = b;
    budget = 0;
    forever begin
      @(negedge clk_sys);
      if (bus.cmd_rdy) break;
      budget++;
      if (budget > 5000) begin
        n_checks++;
        $display("FAIL cmd_accept timeout: byte %h still pending, need acceptance", b);
        break;
      end
    end
    tick();
    bus.cmd_vld  = 1'b0;
    bus.cmd_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] op, a2, a1, a0, x, input bit gaps);
    send_byte(op, gaps);
    send_byte(a2, gaps);
    send_byte(a1, gaps);
    send_byte(a0, gaps);
    send_byte(x, gaps);
  endtask

  task automatic wait_rsp(input int target, input bit bp, input int budget);
    int k;
    k = 0;
    while (rsp_log.size() < target) begin
      bus.rsp_rdy = bp ? 1'($urandom) : 1'b1;
      tick();
      k++;
      if (k > budget) begin
        n_checks++;
        $display("FAIL rsp_timeout: got %0d bytes, need %0d", rsp_log.size(), target);
        break;
      end
    end
    bus.rsp_rdy = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_sys);
    n_checks++;
    if ({bus.cmd_rdy, bus.fx_wr, bus.fx_rd, bus.rsp_vld, bus.bad_op} !== 5'b10000)
      $display("FAIL reset_ctrl: {rdy,wr,rd,vld,bad}=%b need 10000",
               {bus.cmd_rdy, bus.fx_wr, bus.fx_rd, bus.rsp_vld, bus.bad_op});
    else n_pass++;
    n_checks++;
    if ({bus.fx_waddr, bus.fx_raddr} !== 44'd0)
      $display("FAIL reset_addr: waddr=%h raddr=%h need 0", bus.fx_waddr, bus.fx_raddr);
    else n_pass++;
    n_checks++;
    if ({bus.fx_data, bus.rsp_data} !== 16'd0)
      $display("FAIL reset_data: fx_data=%h rsp_data=%h need 0", bus.fx_data, bus.rsp_data);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int wb, rdb, rb;
    wb = wr_log.size(); rdb = rd_log.size(); rb = rsp_log.size();
    send_frame(OP_WR, 8'h01, 8'h23, 8'h45, 8'hA5, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (wr_log.size() - wb !== 1) $display("FAIL write_count: got %0d need 1", wr_log.size() - wb);
    else n_pass++;
    if (wr_log.size() > wb) begin
      n_checks++;
      if (wr_log[wb].a !== 22'h012345 || wr_log[wb].d !== 8'hA5)
        $display("FAIL write_addr_data: got %h/%h need 012345/a5", wr_log[wb].a, wr_log[wb].d);
      else n_pass++;
      n_checks++;
      if (wr_log[wb].c !== acc_log[acc_log.size() - 1].c + 1)
        $display("FAIL write_latency: fx_wr cycle %0d need %0d", wr_log[wb].c,
                 acc_log[acc_log.size() - 1].c + 1);
      else n_pass++;
    end
    n_checks++;
    if (rd_log.size() != rdb || rsp_log.size() != rb)
      $display("FAIL write_no_read: rd %0d rsp %0d new events, need 0", rd_log.size() - rdb,
               rsp_log.size() - rb);
    else n_pass++;
  endtask

  task automatic test_single_read();
    int rdb, rb;
    rdb = rd_log.size(); rb = rsp_log.size();
    q_override = 9'h13C;
    bus.rsp_rdy = 1'b1;
    send_frame(OP_RD, 8'h00, 8'h00, 8'h10, 8'h01, 1'b0);
    wait_rsp(rb + 1, 1'b0, 50);
    @(negedge clk_sys);
    n_checks++;
    if (bus.cmd_rdy !== 1'b1) $display("FAIL read_idle: cmd_rdy=%b need 1", bus.cmd_rdy);
    else n_pass++;
    tick();
    q_override = 9'h000;
    n_checks++;
    if (rd_log.size() - rdb !== 1) $display("FAIL read_count: got %0d need 1", rd_log.size() - rdb);
    else n_pass++;
    if (rd_log.size() > rdb && rsp_log.size() > rb) begin
      n_checks++;
      if (rd_log[rdb].a !== 22'h000010)
        $display("FAIL read_addr: got %h need 000010", rd_log[rdb].a);
      else n_pass++;
      n_checks++;
      if (rsp_log[rb].d !== 8'h3C) $display("FAIL read_data: got %h need 3c", rsp_log[rb].d);
      else n_pass++;
      n_checks++;
      if (rsp_log[rb].c - rd_log[rdb].c !== RD_LAT + 1)
        $display("FAIL read_latency: rsp_vld %0d cycles after fx_rd, need %0d",
                 rsp_log[rb].c - rd_log[rdb].c, RD_LAT + 1);
      else n_pass++;
    end
  endtask

  task automatic test_burst_bp();
    int rdb, rb;
    logic [21:0] ea;
    rdb = rd_log.size(); rb = rsp_log.size();
    seed = 8'($urandom);
    send_frame(OP_RD, 8'h3F, 8'hFF, 8'hFE, 8'h03, 1'b1);
    wait_rsp(rb + 3, 1'b1, 500);
    repeat (3) tick();
    n_checks++;
    if (rd_log.size() - rdb !== 3 || rsp_log.size() - rb !== 3)
      $display("FAIL burst_count: rd %0d rsp %0d, need 3/3", rd_log.size() - rdb, rsp_log.size() - rb);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      ea = 22'(22'h3FFFFE + 22'(i));
      if (rd_log.size() > rdb + i) begin
        n_checks++;
        if (rd_log[rdb + i].a !== ea) $display("FAIL burst_addr[%0d]: got %h need %h", i, rd_log[rdb + i].a, ea);
        else n_pass++;
      end
      if (rsp_log.size() > rb + i) begin
        n_checks++;
        if (rsp_log[rb + i].d !== resp_byte(ea))
          $display("FAIL burst_data[%0d]: got %h need %h", i, rsp_log[rb + i].d, resp_byte(ea));
        else n_pass++;
      end
    end
    n_checks++;
    if (viol_rdv !== 0 || viol_hold !== 0 || viol_both !== 0)
      $display("FAIL burst_protocol: rd_while_vld=%0d hold=%0d both=%0d need 0", viol_rdv, viol_hold, viol_both);
    else n_pass++;
  endtask

  task automatic test_n0();
    int rdb, rb;
    logic [21:0] ea;
    rdb = rd_log.size(); rb = rsp_log.size();
    seed = 8'($urandom);
    bus.rsp_rdy = 1'b1;
    send_frame(OP_RD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    wait_rsp(rb + 256, 1'b0, 256 * (RD_LAT + 4) + 50);
    repeat (RD_LAT + 4) tick();
    n_checks++;
    if (rd_log.size() - rdb !== 256 || rsp_log.size() - rb !== 256)
      $display("FAIL n0_count: rd %0d rsp %0d, need 256/256", rd_log.size() - rdb, rsp_log.size() - rb);
    else n_pass++;
    for (int i = 0; i < 256; i++) begin
      ea = 22'(i);
      if (rd_log.size() > rdb + i) begin
        n_checks++;
        if (rd_log[rdb + i].a !== ea) $display("FAIL n0_addr[%0d]: got %h need %h", i, rd_log[rdb + i].a, ea);
        else n_pass++;
        if (i > 0) begin
          n_checks++;
          if (rd_log[rdb + i].c - rd_log[rdb + i - 1].c !== RD_LAT + 3)
            $display("FAIL n0_spacing[%0d]: got %0d need %0d", i,
                     rd_log[rdb + i].c - rd_log[rdb + i - 1].c, RD_LAT + 3);
          else n_pass++;
        end
      end
      if (rsp_log.size() > rb + i) begin
        n_checks++;
        if (rsp_log[rb + i].d !== resp_byte(ea))
          $display("FAIL n0_data[%0d]: got %h need %h", i, rsp_log[rb + i].d, resp_byte(ea));
        else n_pass++;
      end
    end
  endtask

  task automatic test_bad_op();
    int wb, rdb, bb;
    logic [7:0] op, a2, a1, a0, d;
    wb = wr_log.size(); rdb = rd_log.size(); bb = bad_cnt;
    do op = 8'($urandom); while (op == OP_WR || op == OP_RD);
    a2 = 8'($urandom); a1 = 8'($urandom); a0 = 8'($urandom); d = 8'($urandom);
    send_byte(op, 1'b0);
    send_frame(OP_WR, a2, a1, a0, d, 1'b1);
    repeat (3) tick();
    n_checks++;
    if (bad_cnt - bb !== 1) $display("FAIL bad_op_pulse: %0d cycles high for op %h, need 1", bad_cnt - bb, op);
    else n_pass++;
    n_checks++;
    if (wr_log.size() - wb !== 1 || rd_log.size() != rdb)
      $display("FAIL bad_op_strobes: wr %0d rd %0d, need 1/0", wr_log.size() - wb, rd_log.size() - rdb);
    else n_pass++;
    if (wr_log.size() > wb) begin
      n_checks++;
      if (wr_log[wb].a !== {a2[5:0], a1, a0} || wr_log[wb].d !== d)
        $display("FAIL bad_op_write: got %h/%h need %h/%h", wr_log[wb].a, wr_log[wb].d, {a2[5:0], a1, a0}, d);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int wb, rdb, rb, n;
      logic [7:0] a2, a1, a0, x;
      logic [21:0] base, ea;
      wb = wr_log.size(); rdb = rd_log.size(); rb = rsp_log.size();
      a2 = 8'($urandom); a1 = 8'($urandom); a0 = 8'($urandom); x = 8'($urandom);
      if (f == 5) begin a2 = 8'hFF; a1 = 8'hFF; a0 = 8'hFF; end
      base = {a2[5:0], a1, a0};
      if (f % 2 == 0) begin
        send_frame(OP_WR, a2, a1, a0, x, 1'b1);
        repeat (2) tick();
        n_checks++;
        if (wr_log.size() - wb !== 1 || wr_log[wr_log.size() - 1].a !== base || wr_log[wr_log.size() - 1].d !== x)
          $display("FAIL rand_write[%0d]: count %0d last %h/%h need 1 %h/%h", f, wr_log.size() - wb,
                   wr_log[wr_log.size() - 1].a, wr_log[wr_log.size() - 1].d, base, x);
        else n_pass++;
      end else begin
        n = $urandom_range(1, 4);
        seed = 8'($urandom);
        send_frame(OP_RD, a2, a1, a0, 8'(n), 1'b1);
        wait_rsp(rb + n, 1'b1, 400);
        repeat (2) tick();
        n_checks++;
        if (rd_log.size() - rdb !== n || rsp_log.size() - rb !== n)
          $display("FAIL rand_read_count[%0d]: rd %0d rsp %0d need %0d", f, rd_log.size() - rdb,
                   rsp_log.size() - rb, n);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
          ea = 22'(base + 22'(i));
          if (rd_log.size() > rdb + i && rsp_log.size() > rb + i) begin
            n_checks++;
            if (rd_log[rdb + i].a !== ea || rsp_log[rb + i].d !== resp_byte(ea))
              $display("FAIL rand_read[%0d.%0d]: got %h/%h need %h/%h", f, i, rd_log[rdb + i].a,
                       rsp_log[rb + i].d, ea, resp_byte(ea));
            else n_pass++;
          end
        end
      end
    end
    n_checks++;
    if (viol_rdv !== 0 || viol_hold !== 0 || viol_both !== 0)
      $display("FAIL rand_protocol: rd_while_vld=%0d hold=%0d both=%0d need 0", viol_rdv, viol_hold, viol_both);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int rb, wb, budget;
    logic [7:0] a2, a1, a0, d;
    rb = rsp_log.size();
    bus.rsp_rdy = 1'b1;
    send_frame(OP_RD, 8'h02, 8'h40, 8'h80, 8'h05, 1'b0);
    budget = 0;
    forever begin
      @(negedge clk_sys);
      if (bus.fx_rd && rsp_log.size() >= rb + 1) break;
      budget++;
      if (budget > 200) begin
        n_checks++;
        $display("FAIL mid_burst_timeout: second fx_rd not seen, rsp %0d", rsp_log.size() - rb);
        break;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.fx_rd, bus.fx_wr, bus.rsp_vld, bus.bad_op, bus.cmd_rdy} !== 5'b00001)
      $display("FAIL mid_reset_ctrl: {rd,wr,vld,bad,rdy}=%b need 00001",
               {bus.fx_rd, bus.fx_wr, bus.rsp_vld, bus.bad_op, bus.cmd_rdy});
    else n_pass++;
    n_checks++;
    if (bus.fx_raddr !== 22'd0) $display("FAIL mid_reset_raddr: got %h need 0", bus.fx_raddr);
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wb = wr_log.size();
    a2 = 8'($urandom); a1 = 8'($urandom); a0 = 8'($urandom); d = 8'($urandom);
    send_frame(OP_WR, a2, a1, a0, d, 1'b1);
    repeat (3) tick();
    n_checks++;
    if (rsp_log.size() - rb !== 1)
      $display("FAIL mid_reset_rsp: %0d bytes delivered, need 1", rsp_log.size() - rb);
    else n_pass++;
    n_checks++;
    if (wr_log.size() - wb !== 1 || wr_log[wr_log.size() - 1].a !== {a2[5:0], a1, a0} ||
        wr_log[wr_log.size() - 1].d !== d)
      $display("FAIL post_reset_write: count %0d last %h/%h need 1 %h/%h", wr_log.size() - wb,
               wr_log[wr_log.size() - 1].a, wr_log[wr_log.size() - 1].d, {a2[5:0], a1, a0}, d);
    else n_pass++;
  endtask

  initial begin
    bus.cmd_vld  = 1'b0;
    bus.cmd_data = 8'h00;
    bus.rsp_rdy  = 1'b0;
    test_reset();
    test_write();
    test_single_read();
    test_burst_bp();
    test_n0();
    test_bad_op();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fx_master.md
Name: fx_master

Overview:
- Initiator for the fx register bus: turns a byte-wide command stream from the host interface into single-cycle fx_wr / fx_rd transactions.
- Drives the fx bus ports of the register responders, e.g. the DSP register block and the device-id-addressed peers.
- Read data returns on a byte-wide response stream with valid/ready flow control.
- Supports single writes and auto-incrementing burst reads.

Parameters:
- RD_LAT, 1: cycles from the fx_rd cycle to the fx_q sample cycle; legal range 1..4.
- OP_WR, 8'h57: opcode byte for a write frame.
- OP_RD, 8'h52: opcode byte for a burst-read frame.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_data  in  8  command stream byte.
- cmd_vld  in  1  cmd_data valid.
- cmd_rdy  out  1  master accepts cmd_data; a byte transfers when cmd_vld&cmd_rdy.
- rsp_data  out  8  read data byte.
- rsp_vld  out  1  rsp_data valid.
- rsp_rdy  in  1  downstream accepts; a byte transfers when rsp_vld&rsp_rdy.
- fx_waddr  out  22  write address.
- fx_wr  out  1  write strobe, one cycle per write.
- fx_data  out  8  write data.
- fx_rd  out  1  read strobe, one cycle per byte.
- fx_raddr  out  22  read address.
- fx_q  in  8  read data from the responder.
- bad_op  out  1  one-cycle pulse when an unknown opcode is dropped.

Behaviour:
- Clock and reset: one clock, clk_sys; reset rst_n is asynchronous, active-low. All registers clear immediately on rst_n low.
- Reset values: state IDLE; fx_waddr=0, fx_raddr=0, fx_data=0, fx_wr=0, fx_rd=0, rsp_data=0, rsp_vld=0, bad_op=0.
- cmd_rdy is decoded from state: 1 in IDLE, A2, A1, A0, WDAT, RCNT; 0 elsewhere. It therefore reads 1 in reset.
- Write frame: OP_WR, A2, A1, A0, D.
- Read frame: OP_RD, A2, A1, A0, N.
- Address = {A2[5:0],A1,A0}; A2[7:6] are ignored.
- N=0 means 256 bytes; otherwise N bytes.
- State transitions (each on an accepted byte unless noted):
  - IDLE: OP_WR or OP_RD -> A2, recording the opcode. Any other byte -> bad_op=1 next cycle, stay IDLE.
  - A2 -> A1 -> A0. After A0: -> WDAT for a write, -> RCNT for a read.
  - WDAT: latch fx_data and fx_waddr -> WR.
  - WR (one cycle): fx_wr=1 -> IDLE.
  - RCNT: load fx_raddr and remaining count -> RD.
  - RD (one cycle): fx_rd=1 -> RWAIT.
  - RWAIT: count RD_LAT cycles. On the last one, sample fx_q into rsp_data and set rsp_vld=1 on the next edge -> RSP.
  - RSP: hold rsp_vld/rsp_data until rsp_rdy. On handshake: rsp_vld=0 and fx_raddr+1.
    - Remaining count 0 -> IDLE.
    - Otherwise -> RD on the next cycle.
- fx_waddr, fx_data and fx_raddr hold their last values between transactions. They are stable during their strobe.
- Only one read is ever outstanding, so there is no data loss under rsp_rdy backpressure.
- Latency:
  - Write: fx_wr asserts the cycle after D is accepted.
  - Read: fx_rd asserts the cycle after N is accepted.
  - rsp_vld asserts RD_LAT+1 cycles after the fx_rd cycle.
  - Minimum spacing between burst bytes is RD_LAT+3 cycles with rsp_rdy held 1.
- Address wrap: fx_raddr increments modulo 2^22, so 22'h3FFFFF -> 22'h000000.
- cmd_vld low mid-frame: the FSM waits in the current state indefinitely. There is no timeout.
- cmd bytes presented while cmd_rdy=0 are not consumed.
- rsp_rdy high while rsp_vld=0 has no effect.
- Reset mid-frame or mid-burst: the partial frame is discarded; strobes and rsp_vld drop immediately.
- fx_wr and fx_rd are never both 1.
- bad_op is never 1 outside IDLE-origin decode.

Test Plan:
- Write: cmd 57,01,23,45,A5, cmd_vld held 1 -> exactly one fx_wr cycle with fx_waddr=22'h012345, fx_data=8'hA5, the cycle after A5 is accepted. No rsp_vld.
- Single read, RD_LAT=1: cmd 52,00,00,10,01, responder returns 8'h3C -> one fx_rd with fx_raddr=22'h000010; rsp_data=8'h3C with rsp_vld 2 cycles after fx_rd. Back to IDLE (cmd_rdy=1) after the handshake.
- Burst with backpressure: cmd 52,3F,FF,FE,03, rsp_rdy toggled 0/1 randomly -> fx_raddr sequence 3FFFFE, 3FFFFF, 000000. Exactly 3 fx_rd pulses and 3 response bytes in order; no fx_rd while rsp_vld=1.
- N=0: cmd 52,00,00,00,00 -> exactly 256 fx_rd pulses, addresses 0x000..0x0FF, 256 response bytes.
- Bad opcode: cmd 11 then a valid write frame -> bad_op pulses once; no fx strobe for 11; the following write executes normally.
- Reset mid-burst: rst_n low during byte 2 of an N=5 read -> fx_rd, rsp_vld and bad_op are 0 immediately. After release the FSM is in IDLE and accepts a new write frame correctly.
